uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Transmit side of the UART path, directly downstream of the Wishbone I/O controller's byte strobe (din/din_rdy).
- Buffers bytes in a small FIFO and serialises each as an 8N1 frame on tx, LSB first, at a fixed baud.
- Decouples CPU store bursts from line rate; reports full/empty/overflow status back for polling.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 115200, line rate; bit period DIV = CLK_FREQ/BAUD (integer divide), DIV >= 2 required.
- FIFO_DEPTH, 16, entries; power of two, >= 2.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- din  in  8  byte to transmit, sampled on the accepting cycle.
- din_rdy  in  1  write strobe; level may be held for several cycles; one byte accepted per rising edge.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds zero entries.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (rst_i=0 at a clock edge): tx=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0; FIFO pointers and count cleared; FSM to IDLE; din_rdy edge register cleared to 0. Reset mid-frame aborts the frame; tx is 1 from the next edge.
- Write accept: wr = din_rdy & ~din_rdy_q (din_rdy_q is din_rdy registered). On wr, din is pushed if the FIFO is not full. If full and no pop occurs that cycle, the byte is dropped and overflow is set; overflow clears only on reset.
- Simultaneous push and pop: both take effect and the count is unchanged. When full, a same-cycle pop frees the slot, so the push is accepted and overflow is not set.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. Separate count register, 0..FIFO_DEPTH. full/empty are registered from count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into the shift register, clear the bit counter, load the baud counter, go to START.
  - START: tx=0 for DIV cycles.
  - DATA: tx = shift[0] for DIV cycles per bit; shift right after each bit; 8 bits, then go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Baud counter: counts DIV-1 down to 0; the state/bit advances on the cycle it reads 0.
- Latency: with an idle FIFO, a din_rdy rising edge at edge N gives push at N, pop at N+1, tx=0 from N+2. Frame length is 10*DIV cycles, plus one IDLE cycle between back-to-back frames.
- tx is driven from a register (no combinational glitches).
- busy = (state != IDLE) | ~fifo_empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting DIV cycles, with tx = XOR of the 8 data bits (even parity). Frame is 11*DIV cycles.
- Undefined: no PARITY state, 8N1 framing, 10*DIV cycles.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3, S_PARITY=4);
  - DATA_BITS=8;
  - a DIV computation function.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty/count). The top holds only the edge detect, FSM and baud counter.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so DIV=10; FIFO_DEPTH=4):
- Reset then idle 50 cycles -> tx=1, busy=0, fifo_empty=1, overflow=0 throughout.
- Single byte 0xA5, din_rdy held high 5 cycles -> exactly one frame. tx=0 two cycles after the rising edge, then bits 1,0,1,0,0,1,0,1 each 10 cycles, then stop 1. busy drops after 100 cycles + 1.
- Six rising edges with bytes 0x01..0x06 spaced 2 cycles apart while the first frame runs -> 0x01..0x05 transmitted in order (one popped, four buffered). 0x06 dropped, overflow=1 and stays 1; fifo_full=1 seen during the burst.
- FIFO full and a write edge on the same cycle as the IDLE pop -> byte accepted, overflow stays 0, count unchanged.
- rst_i=0 for 1 cycle at bit 3 of a frame with 2 bytes queued -> tx=1 from the next edge, fifo_empty=1, no further frames.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 for 10 cycles before stop; frame is 110 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// data width and the baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_e;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with separate occupancy count; full/empty are registered
// from the next count so they line up with the pointers.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: din_rdy edge detect, FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] din,
    input  logic       din_rdy,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DIV);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(DIV - 1);

    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 din_rdy_q;
    logic                 overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 wr, push, pop, baud_tick;
    logic [7:0]           head;
    logic [CW-1:0]        fifo_count_unused;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (din),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    always_comb begin
        wr         = din_rdy & ~din_rdy_q;
        pop        = (state_q == S_IDLE) & ~fifo_empty;
        // A same-cycle pop frees a slot, so a write to a full FIFO still lands.
        push       = wr & (~fifo_full | pop);
        overflow_d = overflow_q | (wr & fifo_full & ~pop);
        baud_tick  = (baud_q == '0);
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = 1'b1;
        baud_d     = baud_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != S_IDLE) baud_d = baud_tick ? BAUD_LOAD : baud_q - BW'(1);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = head;
                    bit_d   = '0;
                    baud_d  = BAUD_LOAD;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_tick) state_d = S_DATA;
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BCW'(1);
`ifdef UART_TX_PARITY_EN
                    if (bit_q == BCW'(DATA_BITS - 1)) state_d = S_PARITY;
`else
                    if (bit_q == BCW'(DATA_BITS - 1)) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = parity_q;
                if (baud_tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_tick) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            din_rdy_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            din_rdy_q  <= din_rdy;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE) | ~fifo_empty;
    assign overflow = overflow_q;

endmodule
